// File: rtl/quant_sched_if.sv
// quant_sched_if: job handshake, vector stream, buffer write and quantizer control
// signals of quant_sched, grouped with master/slave views.
interface quant_sched_if #(parameter int ADDR_W = 8);
    logic              i_cfg_valid;
    logic              o_cfg_ready;
    logic [1:0]        i_cfg_mode;
    logic              i_in_valid;
    logic              o_in_ready;
    logic              o_buf_we;
    logic [ADDR_W-1:0] o_buf_addr;
    logic              o_q_start;
    logic              o_q_max_done;
    logic [1:0]        o_q_mode;
    logic              i_q_vec_done;
    logic              i_abort;
    logic              o_busy;
    logic              o_done;
    logic              o_err;

    modport slave (
        input  i_cfg_valid, i_cfg_mode, i_in_valid, i_q_vec_done, i_abort,
        output o_cfg_ready, o_in_ready, o_buf_we, o_buf_addr, o_q_start, o_q_max_done,
               o_q_mode, o_busy, o_done, o_err
    );

    modport master (
        output i_cfg_valid, i_cfg_mode, i_in_valid, i_q_vec_done, i_abort,
        input  o_cfg_ready, o_in_ready, o_buf_we, o_buf_addr, o_q_start, o_q_max_done,
               o_q_mode, o_busy, o_done, o_err
    );
endinterface

// File: rtl/quant_sched.sv
// quant_sched: sequences vector buffering and quantizer start/reduce pulses per job.
// Optional DRAIN watchdog enabled by defining QSCHED_TIMEOUT_EN.
module quant_sched #(
    parameter int VSQ_D  = 16,
    parameter int COL    = 64,
    parameter int ADDR_W = 8
) (
    input logic           i_clk,
    input logic           i_rst_n,
    quant_sched_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, FILL, REDUCE, ISSUE, DRAIN, DONE} state_t;

    localparam logic [ADDR_W-1:0] BEAT_LAST = ADDR_W'(VSQ_D - 1);
    localparam logic [ADDR_W-1:0] TOT_LAST  = ADDR_W'(COL - 1);
    localparam logic [ADDR_W-1:0] BLK_LAST  = ADDR_W'(COL / VSQ_D - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] beat_q, beat_d, blk_q, blk_d, tot_q, tot_d;
    logic [1:0]        red_q, red_d, mode_q, mode_d;
    logic              err_q, err_d, rdy_q;
    logic              vsq, accept, timeout;

    assign vsq    = mode_q == 2'd0;
    assign accept = state_q == FILL && bus.i_in_valid && !bus.i_abort;

`ifdef QSCHED_TIMEOUT_EN
    logic [7:0] to_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) to_q <= '0;
        else          to_q <= state_q == DRAIN ? to_q + 8'd1 : 8'd0;
    end

    assign timeout = state_q == DRAIN && to_q == 8'hff && !bus.i_q_vec_done && !bus.i_abort;
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        blk_d   = blk_q;
        tot_d   = tot_q;
        mode_d  = mode_q;
        red_d   = 2'd0;
        err_d   = 1'b0;
        if (bus.i_abort || timeout) begin
            state_d = IDLE;
            beat_d  = '0;
            blk_d   = '0;
            tot_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (rdy_q && bus.i_cfg_valid) begin
                    mode_d  = bus.i_cfg_mode;
                    beat_d  = '0;
                    blk_d   = '0;
                    tot_d   = '0;
                    err_d   = &bus.i_cfg_mode;
                    state_d = &bus.i_cfg_mode ? IDLE : FILL;
                end
                FILL: if (accept) begin
                    beat_d  = beat_q == BEAT_LAST ? '0 : beat_q + 1'b1;
                    tot_d   = tot_q == TOT_LAST ? '0 : tot_q + 1'b1;
                    state_d = vsq ? (beat_q == BEAT_LAST ? ISSUE : FILL)
                                  : (tot_q == TOT_LAST ? REDUCE : FILL);
                end
                REDUCE: begin
                    red_d   = red_q + 2'd1;
                    state_d = red_q == 2'd3 ? ISSUE : REDUCE;
                end
                ISSUE: state_d = DRAIN;
                DRAIN: if (bus.i_q_vec_done) begin
                    blk_d   = blk_q == BLK_LAST ? '0 : blk_q + 1'b1;
                    beat_d  = vsq ? '0 : beat_q;
                    state_d = blk_q == BLK_LAST ? DONE : (vsq ? FILL : ISSUE);
                end
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Ready is registered so it stays low through reset and rises one clock after release.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            blk_q   <= '0;
            tot_q   <= '0;
            red_q   <= '0;
            mode_q  <= '0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            blk_q   <= blk_d;
            tot_q   <= tot_d;
            red_q   <= red_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
            rdy_q   <= state_d == IDLE;
        end
    end

    assign bus.o_cfg_ready  = rdy_q;
    assign bus.o_in_ready   = state_q == FILL;
    assign bus.o_buf_we     = accept;
    assign bus.o_buf_addr   = vsq ? beat_q : tot_q;
    assign bus.o_q_start    = state_q == ISSUE;
    assign bus.o_q_max_done = accept && !vsq && tot_q == TOT_LAST;
    assign bus.o_q_mode     = mode_q;
    assign bus.o_busy       = state_q != IDLE;
    assign bus.o_done       = state_q == DONE && !bus.i_abort;
    assign bus.o_err        = err_q || timeout;
endmodule

// File: tb/tb_quant_sched.sv
// tb_quant_sched: directed checks of quant_sched job sequencing, abort, reset and errors.
module tb_quant_sched;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   ack_en = 1'b1;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, n_we = 0, n_start = 0, n_max = 0, n_done = 0, n_err = 0, bad_rdy = 0;
    int max_cyc = 0, max_we_idx = 0, err_cyc = 0;
    logic [7:0] addrs[$];
    int starts[$];

    quant_sched_if #(.ADDR_W(8)) bus ();

    quant_sched #(.VSQ_D(16), .COL(64), .ADDR_W(8)) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (bus.o_buf_we) begin n_we++; addrs.push_back(bus.o_buf_addr); end
        if (bus.o_q_start) begin n_start++; starts.push_back(cyc); end
        if (bus.o_q_max_done) begin n_max++; max_cyc = cyc; max_we_idx = n_we; end
        if (bus.o_done) n_done++;
        if (bus.o_err) begin n_err++; err_cyc = cyc; end
        if (bus.o_in_ready && (!bus.o_busy || bus.o_q_start)) bad_rdy++;
    end

    // Quantizer model: answers each start with a block-complete pulse a few cycles later.
    initial begin
        bus.i_q_vec_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.o_q_start && ack_en) begin
                repeat (3) @(posedge clk);
                #2 bus.i_q_vec_done = 1'b1;
                @(posedge clk);
                #2 bus.i_q_vec_done = 1'b0;
            end
        end
    end

    task automatic run_job(input logic [1:0] mode, input bit rnd, output bit ok);
        int d0 = n_done;
        int k = 0;
        @(posedge clk); #2;
        bus.i_cfg_valid = 1'b1;
        bus.i_cfg_mode  = mode;
        @(posedge clk); #2;
        bus.i_cfg_valid = 1'b0;
        while (n_done == d0 && k < 3000) begin
            bus.i_in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #2;
            k++;
        end
        bus.i_in_valid = 1'b0;
        ok = n_done != d0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.o_cfg_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready got=%b want=0", bus.o_cfg_ready); end
        n_cmp++; if ({bus.o_busy, bus.o_done, bus.o_err, bus.o_buf_we, bus.o_q_start, bus.o_q_max_done, bus.o_in_ready} !== 7'b0) begin
            n_bad++; $display("FAIL reset_outputs got=%b want=0000000", {bus.o_busy, bus.o_done, bus.o_err, bus.o_buf_we, bus.o_q_start, bus.o_q_max_done, bus.o_in_ready}); end
        n_cmp++; if (bus.o_q_mode !== 2'd0) begin n_bad++; $display("FAIL reset_mode got=%0d want=0", bus.o_q_mode); end
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.o_cfg_ready !== 1'b0) begin n_bad++; $display("FAIL ready_before_clock got=%b want=0", bus.o_cfg_ready); end
        @(negedge clk);
        n_cmp++; if (bus.o_cfg_ready !== 1'b1) begin n_bad++; $display("FAIL ready_after_release got=%b want=1", bus.o_cfg_ready); end
    endtask

    task automatic test_vsq();
        int w0 = n_we, s0 = n_start, d0 = n_done, m0 = n_max, a0 = addrs.size(), bad = 0;
        bit ok;
        run_job(2'd0, 1'b0, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL vsq_finished got=%b want=1", ok); end
        n_cmp++; if (n_we - w0 !== 64) begin n_bad++; $display("FAIL vsq_writes got=%0d want=64", n_we - w0); end
        for (int i = 0; i < 64 && a0 + i < addrs.size(); i++) if (addrs[a0 + i] !== 8'(i % 16)) bad++;
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL vsq_addrs got=%0d bad want=0", bad); end
        n_cmp++; if (n_start - s0 !== 4) begin n_bad++; $display("FAIL vsq_starts got=%0d want=4", n_start - s0); end
        n_cmp++; if (n_done - d0 !== 1) begin n_bad++; $display("FAIL vsq_done got=%0d want=1", n_done - d0); end
        n_cmp++; if (n_max - m0 !== 0) begin n_bad++; $display("FAIL vsq_maxdone got=%0d want=0", n_max - m0); end
        n_cmp++; if (bus.o_q_mode !== 2'd0) begin n_bad++; $display("FAIL vsq_mode got=%0d want=0", bus.o_q_mode); end
    endtask

    task automatic test_int8();
        int w0 = n_we, s0 = n_start, d0 = n_done, m0 = n_max, a0 = addrs.size(), bad = 0, gap = -1;
        bit ok;
        run_job(2'd2, 1'b0, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL int8_finished got=%b want=1", ok); end
        n_cmp++; if (n_we - w0 !== 64) begin n_bad++; $display("FAIL int8_writes got=%0d want=64", n_we - w0); end
        for (int i = 0; i < 64 && a0 + i < addrs.size(); i++) if (addrs[a0 + i] !== 8'(i)) bad++;
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL int8_addrs got=%0d bad want=0", bad); end
        n_cmp++; if (n_max - m0 !== 1) begin n_bad++; $display("FAIL int8_maxdone_count got=%0d want=1", n_max - m0); end
        n_cmp++; if (max_we_idx - w0 !== 64) begin n_bad++; $display("FAIL int8_maxdone_beat got=%0d want=64", max_we_idx - w0); end
        for (int i = s0; i < starts.size(); i++) if (gap < 0 && starts[i] > max_cyc) gap = starts[i] - max_cyc;
        n_cmp++; if (gap !== 5) begin n_bad++; $display("FAIL int8_start_gap got=%0d want=5", gap); end
        n_cmp++; if (n_start - s0 !== 4) begin n_bad++; $display("FAIL int8_starts got=%0d want=4", n_start - s0); end
        n_cmp++; if (n_done - d0 !== 1) begin n_bad++; $display("FAIL int8_done got=%0d want=1", n_done - d0); end
        n_cmp++; if (bus.o_q_mode !== 2'd2) begin n_bad++; $display("FAIL int8_mode got=%0d want=2", bus.o_q_mode); end
    endtask

    task automatic test_bad_mode();
        int w0 = n_we, e0 = n_err;
        @(posedge clk); #2;
        bus.i_cfg_valid = 1'b1;
        bus.i_cfg_mode  = 2'd3;
        @(posedge clk); #2;
        bus.i_cfg_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.o_err !== 1'b1) begin n_bad++; $display("FAIL badmode_err got=%b want=1", bus.o_err); end
        n_cmp++; if (bus.o_busy !== 1'b0) begin n_bad++; $display("FAIL badmode_busy got=%b want=0", bus.o_busy); end
        n_cmp++; if (bus.o_cfg_ready !== 1'b1) begin n_bad++; $display("FAIL badmode_ready got=%b want=1", bus.o_cfg_ready); end
        repeat (3) @(negedge clk);
        n_cmp++; if (n_err - e0 !== 1) begin n_bad++; $display("FAIL badmode_err_pulses got=%0d want=1", n_err - e0); end
        n_cmp++; if (n_we - w0 !== 0) begin n_bad++; $display("FAIL badmode_writes got=%0d want=0", n_we - w0); end
    endtask

    task automatic test_abort();
        int s0 = n_start, d0 = n_done, k = 0, w0, a0;
        int bad = 0;
        bit ok;
        @(posedge clk); #2;
        bus.i_cfg_valid = 1'b1;
        bus.i_cfg_mode  = 2'd1;
        @(posedge clk); #2;
        bus.i_cfg_valid = 1'b0;
        bus.i_in_valid  = 1'b1;
        while (n_start - s0 < 2 && k < 500) begin @(negedge clk); #1; k++; end
        bus.i_in_valid = 1'b0;
        n_cmp++; if (n_start - s0 !== 2) begin n_bad++; $display("FAIL abort_reach_block2 got=%0d want=2", n_start - s0); end
        @(posedge clk); #2 bus.i_abort = 1'b1;
        @(posedge clk); #2 bus.i_abort = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.o_busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got=%b want=0", bus.o_busy); end
        n_cmp++; if (bus.o_cfg_ready !== 1'b1) begin n_bad++; $display("FAIL abort_ready got=%b want=1", bus.o_cfg_ready); end
        repeat (8) @(negedge clk);
        n_cmp++; if (n_done - d0 !== 0) begin n_bad++; $display("FAIL abort_no_done got=%0d want=0", n_done - d0); end
        w0 = n_we; a0 = addrs.size(); s0 = n_start;
        run_job(2'd0, 1'b0, ok);
        for (int i = 0; i < 64 && a0 + i < addrs.size(); i++) if (addrs[a0 + i] !== 8'(i % 16)) bad++;
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL abort_rerun_finished got=%b want=1", ok); end
        n_cmp++; if (n_we - w0 !== 64 || bad !== 0) begin n_bad++; $display("FAIL abort_rerun_writes got=%0d bad=%0d want=64 bad=0", n_we - w0, bad); end
        n_cmp++; if (n_start - s0 !== 4) begin n_bad++; $display("FAIL abort_rerun_starts got=%0d want=4", n_start - s0); end
    endtask

    task automatic test_random_stream();
        int w0 = n_we, d0 = n_done, a0 = addrs.size(), bad = 0;
        bit ok;
        run_job(2'd2, 1'b1, ok);
        for (int i = 0; i < 64 && a0 + i < addrs.size(); i++) if (addrs[a0 + i] !== 8'(i)) bad++;
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL random_finished got=%b want=1", ok); end
        n_cmp++; if (n_we - w0 !== 64) begin n_bad++; $display("FAIL random_writes got=%0d want=64", n_we - w0); end
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL random_addrs got=%0d bad want=0", bad); end
        n_cmp++; if (n_done - d0 !== 1) begin n_bad++; $display("FAIL random_done got=%0d want=1", n_done - d0); end
        n_cmp++; if (bad_rdy !== 0) begin n_bad++; $display("FAIL in_ready_outside_fill got=%0d want=0", bad_rdy); end
    endtask

    task automatic test_stall_and_reset();
        int w0, d0 = n_done;
        @(posedge clk); #2;
        bus.i_cfg_valid = 1'b1;
        bus.i_cfg_mode  = 2'd2;
        @(posedge clk); #2;
        bus.i_cfg_valid = 1'b0;
        bus.i_in_valid  = 1'b1;
        repeat (10) @(posedge clk);
        #2 bus.i_in_valid = 1'b0;
        w0 = n_we;
        repeat (20) @(negedge clk);
        n_cmp++; if (n_we - w0 !== 0) begin n_bad++; $display("FAIL stall_writes got=%0d want=0", n_we - w0); end
        n_cmp++; if (bus.o_in_ready !== 1'b1) begin n_bad++; $display("FAIL stall_ready got=%b want=1", bus.o_in_ready); end
        n_cmp++; if (bus.o_buf_addr !== 8'd10) begin n_bad++; $display("FAIL stall_addr got=%0d want=10", bus.o_buf_addr); end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.o_busy !== 1'b0 || bus.o_q_mode !== 2'd0) begin n_bad++; $display("FAIL midreset got busy=%b mode=%0d want busy=0 mode=0", bus.o_busy, bus.o_q_mode); end
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++; if (n_done - d0 !== 0 || bus.o_cfg_ready !== 1'b1) begin n_bad++; $display("FAIL midreset_after got done=%0d ready=%b want done=0 ready=1", n_done - d0, bus.o_cfg_ready); end
    endtask

`ifdef QSCHED_TIMEOUT_EN
    task automatic test_timeout();
        int s0 = n_start, e0 = n_err, k = 0, sc;
        ack_en = 1'b0;
        @(posedge clk); #2;
        bus.i_cfg_valid = 1'b1;
        bus.i_cfg_mode  = 2'd0;
        @(posedge clk); #2;
        bus.i_cfg_valid = 1'b0;
        bus.i_in_valid  = 1'b1;
        while (n_start == s0 && k < 100) begin @(negedge clk); #1; k++; end
        bus.i_in_valid = 1'b0;
        sc = n_start != s0 ? starts[starts.size() - 1] : 0;
        k = 0;
        while (n_err == e0 && k < 400) begin @(negedge clk); #1; k++; end
        n_cmp++; if (n_err - e0 !== 1) begin n_bad++; $display("FAIL timeout_err got=%0d want=1", n_err - e0); end
        n_cmp++; if (err_cyc - (sc + 1) !== 255) begin n_bad++; $display("FAIL timeout_delay got=%0d want=255", err_cyc - (sc + 1)); end
        @(negedge clk);
        n_cmp++; if (bus.o_busy !== 1'b0 || bus.o_cfg_ready !== 1'b1) begin n_bad++; $display("FAIL timeout_idle got busy=%b ready=%b want 0/1", bus.o_busy, bus.o_cfg_ready); end
        ack_en = 1'b1;
    endtask
`endif

    initial begin
        bus.i_cfg_valid = 1'b0;
        bus.i_cfg_mode  = 2'd0;
        bus.i_in_valid  = 1'b0;
        bus.i_abort     = 1'b0;
        test_reset();
        test_vsq();
        test_int8();
        test_bad_mode();
        test_abort();
        test_random_stream();
        test_stall_and_reset();
`ifdef QSCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
